kernel_stream_driver: RTL and testbench

Stream source for the two-input kernel tops: reads element pairs (u, v) from two synchronous-read buffers and presents them as valid/ready streams to a kernel's `u`/`v` inputs. It honours the kernel's single combined `iready` and raises the two per-stream valids together, so the kernel's AND of its input valids always sees a matched pair. It sits between the host-loaded buffers and the kernel top, and reports completion and stall statistics to the controller.

---
 rtl/kernel_stream_pkg.sv | 23 ++
 rtl/stream_fifo2.sv | 75 +++++++
 rtl/kernel_stream_driver.sv | 175 +++++++++++++++++
 tb/tb_kernel_stream_driver.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kernel_stream_pkg.sv
// kernel_stream_pkg
//   Shared definitions for the kernel stream driver:
//   - default stream data and buffer address widths
//   - depth of the output skid FIFO
//   - driver FSM state encoding
//   - saturating increment helper for the 32-bit stall counter
package kernel_stream_pkg;

    localparam int DEF_STREAMW = 32;
    localparam int DEF_ADDRW   = 10;
    localparam int FIFO_DEPTH  = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

    function automatic logic [31:0] sat_inc32(input logic [31:0] x);
        return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
    endfunction

endpackage

// File: rtl/stream_fifo2.sv
// stream_fifo2
//   Two-entry FIFO holding read data until the kernel accepts it. Entry 0 is
//   always the head, so the head output needs no read mux. Push and pop in
//   the same cycle are legal in every occupancy; a pop while empty is
//   ignored, and a push while full is accepted only together with a pop.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   push_i     write wdata_i at the tail this cycle
//   wdata_i    data to write
//   pop_i      discard the head this cycle
//   head_o     current head entry (meaningful when count_o != 0)
//   count_o    occupancy, 0..2
module stream_fifo2
    import kernel_stream_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] slot0_q, slot0_d;
    logic [W-1:0] slot1_q, slot1_d;
    logic [1:0]   count_q, count_d;
    logic         pop_eff;
    logic         push_eff;
    logic [1:0]   wpos;

    assign pop_eff  = pop_i && (count_q != 2'd0);
    assign push_eff = push_i && ((count_q != 2'(FIFO_DEPTH)) || pop_eff);
    // Tail position after this cycle's pop has shifted the entries down.
    assign wpos     = count_q - {1'b0, pop_eff};

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q + {1'b0, push_eff} - {1'b0, pop_eff};
        if (pop_eff) begin
            slot0_d = slot1_q;
        end
        if (push_eff) begin
            if (wpos == 2'd0) begin
                slot0_d = wdata_i;
            end else begin
                slot1_d = wdata_i;
            end
        end
    end

    // NOTE: the two storage slots are reset along with the count because the
    // head drives the stream data outputs directly, and those must read zero
    // out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

    assign head_o  = slot0_q;
    assign count_o = count_q;

endmodule

// File: rtl/kernel_stream_driver.sv
// kernel_stream_driver
//   Reads (u, v) element pairs from two synchronous-read buffers sharing one
//   address, and presents them to a two-input kernel as a pair of
//   valid/ready streams whose valids always rise and fall together.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   start, nelems             launch a run of nelems elements (idle only)
//   busy, done                run in progress / one-cycle end-of-run pulse
//   stall_cycles              saturating count of valid-but-not-ready cycles
//   mem_ren, mem_raddr        shared buffer read port
//   mem_rdata_u, mem_rdata_v  read data, one cycle after mem_ren
//   u, v, ivalid_u, ivalid_v  stream outputs to the kernel
//   iready                    kernel combined ready
module kernel_stream_driver
    import kernel_stream_pkg::*;
#(
    parameter int STREAMW = DEF_STREAMW,
    parameter int ADDRW   = DEF_ADDRW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDRW:0]     nelems,
    output logic               busy,
    output logic               done,
    output logic [31:0]        stall_cycles,
    output logic               mem_ren,
    output logic [ADDRW-1:0]   mem_raddr,
    input  logic [STREAMW-1:0] mem_rdata_u,
    input  logic [STREAMW-1:0] mem_rdata_v,
    output logic [STREAMW-1:0] u,
    output logic [STREAMW-1:0] v,
    output logic               ivalid_u,
    output logic               ivalid_v,
    input  logic               iready
);

    localparam logic [ADDRW:0] CNT_ONE = {{ADDRW{1'b0}}, 1'b1};

    state_e             state_q;
    logic [ADDRW:0]     nelems_q;
    logic [ADDRW:0]     rd_cnt_q;
    logic [ADDRW:0]     out_cnt_q;
    logic               inflight_q;
    logic [31:0]        stall_q;
    logic               busy_q;
    logic               done_q;

    logic [1:0]           fifo_count;
    logic [2*STREAMW-1:0] fifo_head;
    logic                 valid;
    logic                 pop;
    logic                 credit;
    logic                 issue;
    logic                 last_hs;
    logic [2:0]           credit_used;
    logic [2:0]           credit_limit;

    // ------------------------------------------------------------------
    // Stream side
    // ------------------------------------------------------------------
    assign valid = (fifo_count != 2'd0);
    assign pop   = valid && iready;

    stream_fifo2 #(
        .W (2*STREAMW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (inflight_q),
        .wdata_i ({mem_rdata_u, mem_rdata_v}),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .count_o (fifo_count)
    );

    assign u        = fifo_head[2*STREAMW-1:STREAMW];
    assign v        = fifo_head[STREAMW-1:0];
    assign ivalid_u = valid;
    assign ivalid_v = valid;

    // ------------------------------------------------------------------
    // Read issue
    // ------------------------------------------------------------------
    // Entries already buffered plus the one read in flight must leave room
    // for one more. Counting this cycle's pop as freed space (written as
    // used < 2 + pop to stay unsigned) lets issuing restart in the very
    // cycle backpressure clears, so there is no bubble after a stall.
    assign credit_used  = {1'b0, fifo_count} + {2'b00, inflight_q};
    assign credit_limit = 3'd2 + {2'b00, pop};
    assign credit       = (credit_used < credit_limit);

    // Issue stays combinational: it depends on this cycle's iready through
    // the pop-aware credit.
    assign issue     = (state_q == ST_RUN) && (rd_cnt_q < nelems_q) && credit;
    assign mem_ren   = issue;
    assign mem_raddr = issue ? rd_cnt_q[ADDRW-1:0] : '0;

    // Compare against out_cnt+1 rather than nelems-1 so a zero count can
    // never underflow into a spurious match.
    assign last_hs = pop && ((out_cnt_q + CNT_ONE) == nelems_q);

    // ------------------------------------------------------------------
    // Control FSM, counters and registered status outputs
    // ------------------------------------------------------------------
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the values from before this edge, whatever the statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            nelems_q   <= '0;
            rd_cnt_q   <= '0;
            out_cnt_q  <= '0;
            inflight_q <= 1'b0;
            stall_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // Read data is captured by the FIFO the cycle after the request.
            inflight_q <= issue;

            unique case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        nelems_q  <= nelems;
                        rd_cnt_q  <= '0;
                        out_cnt_q <= '0;
                        stall_q   <= '0;
                        if (nelems == '0) begin
                            state_q <= ST_FINISH;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                end

                ST_RUN: begin
                    if (issue) begin
                        rd_cnt_q <= rd_cnt_q + CNT_ONE;
                    end
                    if (pop) begin
                        out_cnt_q <= out_cnt_q + CNT_ONE;
                    end
                    if (valid && !iready) begin
                        stall_q <= sat_inc32(stall_q);
                    end
                    if (last_hs) begin
                        state_q <= ST_FINISH;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end

                ST_FINISH: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_kernel_stream_driver.sv
module tb_kernel_stream_driver;

    localparam int STREAMW = 32;
    localparam int ADDRW   = 10;
    localparam int DEPTH   = 1 << ADDRW;

    logic               clk;
    logic               rst;
    logic               start;
    logic [ADDRW:0]     nelems;
    logic               busy;
    logic               done;
    logic [31:0]        stall_cycles;
    logic               mem_ren;
    logic [ADDRW-1:0]   mem_raddr;
    logic [STREAMW-1:0] mem_rdata_u;
    logic [STREAMW-1:0] mem_rdata_v;
    logic [STREAMW-1:0] u;
    logic [STREAMW-1:0] v;
    logic               ivalid_u;
    logic               ivalid_v;
    logic               iready;

    kernel_stream_driver #(
        .STREAMW (STREAMW),
        .ADDRW   (ADDRW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .nelems       (nelems),
        .busy         (busy),
        .done         (done),
        .stall_cycles (stall_cycles),
        .mem_ren      (mem_ren),
        .mem_raddr    (mem_raddr),
        .mem_rdata_u  (mem_rdata_u),
        .mem_rdata_v  (mem_rdata_v),
        .u            (u),
        .v            (v),
        .ivalid_u     (ivalid_u),
        .ivalid_v     (ivalid_v),
        .iready       (iready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Host-loaded buffers with one-cycle synchronous read.
    logic [STREAMW-1:0] mem_u [DEPTH];
    logic [STREAMW-1:0] mem_v [DEPTH];

    initial begin
        mem_rdata_u = '0;
        mem_rdata_v = '0;
    end

    always @(posedge clk) begin
        if (mem_ren) begin
            mem_rdata_u <= mem_u[mem_raddr];
            mem_rdata_v <= mem_v[mem_raddr];
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Observations from the most recent run.
    bit                 ready_hist [8192];
    logic [STREAMW-1:0] hs_u [$];
    logic [STREAMW-1:0] hs_v [$];
    int                 hs_c [$];
    int                 obs_done_cyc;
    int                 obs_stall;

    function automatic bit ready_pat(input int mode, input int c);
        case (mode)
            0:       return 1'b1;
            1:       return !(c >= 4 && c <= 6);
            default: return ($urandom_range(0, 2) != 0);
        endcase
    endfunction

    // Launches one run, records every cycle until two cycles after done, then
    // checks the record against a reference model. The model only uses the
    // stream contract: valid is continuous from cycle 3, so the k-th
    // handshake is the k-th ready cycle at or after cycle 3, done follows the
    // last handshake, and stalls are the non-ready cycles in between.
    task automatic run(input int n, input int mode, input int restart_cyc,
                       input int max_cyc, input string tag);
        int  cyc;
        int  done_cnt, busy_cnt, ren_cnt, ren_first, ren4_6, last_addr;
        int  first_valid, vmis, unstable, outst, max_outst;
        bit  timeout, prev_hold;
        logic [STREAMW-1:0] prev_u, prev_v;
        int  exp_c [$];
        int  exp_done, exp_stall, k;

        hs_u.delete(); hs_v.delete(); hs_c.delete();
        done_cnt = 0; busy_cnt = 0; ren_cnt = 0; ren_first = -1; ren4_6 = 0;
        last_addr = -1; first_valid = -1; vmis = 0; unstable = 0;
        max_outst = 0; timeout = 0; prev_hold = 0; prev_u = '0; prev_v = '0;
        obs_done_cyc = -1;
        for (int i = 0; i < 8192; i++) ready_hist[i] = 1'b0;

        @(negedge clk);
        start  = 1'b1;
        nelems = (ADDRW+1)'(n);
        iready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
        iready = ready_pat(mode, cyc);
        ready_hist[cyc] = iready;

        forever begin
            if (cyc == restart_cyc) start = 1'b1;
            @(negedge clk);
            if (done) begin
                done_cnt++;
                if (obs_done_cyc < 0) obs_done_cyc = cyc;
            end
            if (busy) busy_cnt++;
            if (mem_ren) begin
                ren_cnt++;
                if (ren_first < 0) ren_first = cyc;
                if (cyc >= 4 && cyc <= 6) ren4_6++;
                last_addr = int'(mem_raddr);
            end
            if (ivalid_u !== ivalid_v) vmis++;
            if (ivalid_u && first_valid < 0) first_valid = cyc;
            if (prev_hold && (!ivalid_u || u !== prev_u || v !== prev_v)) unstable++;
            prev_hold = ivalid_u && !iready;
            prev_u = u;
            prev_v = v;
            if (ivalid_u && iready) begin
                hs_u.push_back(u);
                hs_v.push_back(v);
                hs_c.push_back(cyc);
            end
            outst = ren_cnt - hs_c.size();
            if (outst > max_outst) max_outst = outst;

            if (obs_done_cyc >= 0 && cyc >= obs_done_cyc + 2) break;
            if (cyc >= max_cyc) begin
                timeout = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            cyc++;
            start = 1'b0;
            iready = ready_pat(mode, cyc);
            ready_hist[cyc] = iready;
        end
        obs_stall = int'(stall_cycles);

        // Reference model.
        k = 0;
        for (int c = 3; c <= cyc; c++) begin
            if (k < n && ready_hist[c]) begin
                exp_c.push_back(c);
                k++;
            end
        end
        exp_done  = (n == 0) ? 1 : ((exp_c.size() > 0) ? exp_c[exp_c.size()-1] + 1 : -1);
        exp_stall = 0;
        for (int c = 3; c < exp_done; c++) begin
            if (!ready_hist[c]) exp_stall++;
        end

        check({tag, " timeout"}, 64'(timeout), 64'(0));
        check({tag, " handshakes"}, 64'(hs_c.size()), 64'(n));
        for (int i = 0; i < hs_c.size() && i < n; i++) begin
            check($sformatf("%s hs%0d u", tag, i), 64'(hs_u[i]), 64'(mem_u[i]));
            check($sformatf("%s hs%0d v", tag, i), 64'(hs_v[i]), 64'(mem_v[i]));
            if (i < exp_c.size())
                check($sformatf("%s hs%0d cycle", tag, i), 64'(hs_c[i]), 64'(exp_c[i]));
        end
        check({tag, " done pulses"}, 64'(done_cnt), 64'(1));
        check({tag, " done cycle"}, 64'(obs_done_cyc), 64'(exp_done));
        check({tag, " busy cycles"}, 64'(busy_cnt), 64'(exp_done - 1));
        check({tag, " reads"}, 64'(ren_cnt), 64'(n));
        check({tag, " first read cycle"}, 64'(ren_first), 64'((n == 0) ? -1 : 1));
        check({tag, " first valid cycle"}, 64'(first_valid), 64'((n == 0) ? -1 : 3));
        check({tag, " valid pair mismatch"}, 64'(vmis), 64'(0));
        check({tag, " data unstable"}, 64'(unstable), 64'(0));
        check({tag, " stall cycles"}, 64'(obs_stall), 64'(exp_stall));
        if (n > 0) check({tag, " last address"}, 64'(last_addr), 64'(n - 1));
        if (n >= 2) check({tag, " max buffered"}, 64'(max_outst), 64'(2));
        if (mode == 1) check({tag, " reads while held"}, 64'(ren4_6), 64'(0));
    endtask

    typedef struct {
        int    n;
        int    mode;
        int    exp_done;
        int    exp_stall;
        string name;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{4, 0, 7,  0, "basic4"};
        vecs[1] = '{8, 1, 14, 3, "backpressure8"};
        vecs[2] = '{0, 0, 1,  0, "zero"};
        vecs[3] = '{1, 0, 4,  0, "single"};
        vecs[4] = '{2, 1, 8,  3, "backpressure2"};
        vecs[5] = '{3, 1, 9,  3, "backpressure3"};

        for (int i = 0; i < DEPTH; i++) begin
            mem_u[i] = STREAMW'(i);
            mem_v[i] = STREAMW'(32'h100 + i);
        end

        rst    = 1'b1;
        start  = 1'b0;
        nelems = '0;
        iready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy", 64'(busy), 64'(0));
        check("reset done", 64'(done), 64'(0));
        check("reset mem_ren", 64'(mem_ren), 64'(0));
        check("reset mem_raddr", 64'(mem_raddr), 64'(0));
        check("reset ivalid_u", 64'(ivalid_u), 64'(0));
        check("reset ivalid_v", 64'(ivalid_v), 64'(0));
        check("reset stall", 64'(stall_cycles), 64'(0));
        check("reset u", 64'(u), 64'(0));
        check("reset v", 64'(v), 64'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run(vecs[i].n, vecs[i].mode, 0, 60, vecs[i].name);
            check({vecs[i].name, " done cycle (table)"}, 64'(obs_done_cyc), 64'(vecs[i].exp_done));
            check({vecs[i].name, " stall (table)"}, 64'(obs_stall), 64'(vecs[i].exp_stall));
        end

        // A start in cycle 3 of a running 4-element transfer is ignored.
        run(4, 0, 3, 60, "busy_guard");
        check("busy_guard idle after", 64'(busy), 64'(0));
        check("busy_guard done cycle", 64'(obs_done_cyc), 64'(7));

        // Asynchronous reset in cycle 4 of an 8-element run.
        @(negedge clk);
        start  = 1'b1;
        nelems = (ADDRW+1)'(8);
        iready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check("midrst valid before", 64'(ivalid_u), 64'(1));
        check("midrst busy before", 64'(busy), 64'(1));
        rst = 1'b1;
        #1;
        check("midrst busy", 64'(busy), 64'(0));
        check("midrst ivalid_u", 64'(ivalid_u), 64'(0));
        check("midrst ivalid_v", 64'(ivalid_v), 64'(0));
        check("midrst mem_ren", 64'(mem_ren), 64'(0));
        check("midrst stall", 64'(stall_cycles), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run(2, 0, 0, 60, "after_reset");

        // Whole buffer with random data and random backpressure.
        for (int i = 0; i < DEPTH; i++) begin
            mem_u[i] = $urandom;
            mem_v[i] = $urandom;
        end
        run(DEPTH, 2, 0, 6000, "full_random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
